// File: rtl/fft16_bitrev_reorder_pkg.sv
// fft16_bitrev_reorder_pkg: shared FFT sizes, sample field slices, state encodings and the bit-reverse helper.
package fft16_bitrev_reorder_pkg;
  localparam int LOG2N = 4;
  localparam int N = 1 << LOG2N;
  localparam int W = 24;
  localparam int RE_MSB = 23;
  localparam int RE_LSB = 12;
  localparam int IM_MSB = 11;
  localparam int IM_LSB = 0;
  typedef enum logic {SYNC, FILL} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RUN} rd_state_e;
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/reorder_bank.sv
// reorder_bank: one frame of sample registers, single write port, combinational read port, contents never reset.
module reorder_bank
  import fft16_bitrev_reorder_pkg::*;
#(
  parameter int AW = LOG2N,
  parameter int DW = W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [2**AW];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fft16_bitrev_reorder.sv
// fft16_bitrev_reorder: ping-pong buffer that turns bit-reversed FFT frames back into natural order.
module fft16_bitrev_reorder #(
  parameter int LOG2N = fft16_bitrev_reorder_pkg::LOG2N,
  parameter int W = fft16_bitrev_reorder_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in,
  input  logic         in_valid,
  input  logic         in_first,
  output logic [W-1:0] out,
  output logic         out_valid,
  output logic         out_first,
  output logic         frame_err
);
  import fft16_bitrev_reorder_pkg::*;
  wr_state_e wst_q, wst_d;
  rd_state_e rd_q, rd_d;
  logic [LOG2N-1:0] wk_q, wk_d, rn_q, rn_d, waddr;
  logic wsel_q, wsel_d, rsel_q, rsel_d, wr_en, set_full, clr_full, fire;
  logic [1:0] full_q, full_d;
  logic [W-1:0] out_q, out_d;
  logic out_valid_q, out_valid_d, out_first_q, out_first_d, frame_err_q, frame_err_d;
  logic [W-1:0] rdata [2];
  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(.AW(LOG2N), .DW(W)) u_bank (
      .clk   (clk),
      .we    (wr_en && wsel_q == 1'(b)),
      .waddr (waddr),
      .wdata (in),
      .raddr (rn_q),
      .rdata (rdata[b])
    );
  end
  // An early in_first restarts the current bank at position 0 instead of advancing.
  always_comb begin
    wst_d = wst_q;
    wk_d = wk_q;
    wsel_d = wsel_q;
    wr_en = 1'b0;
    waddr = bitrev(wk_q);
    frame_err_d = 1'b0;
    set_full = 1'b0;
    if (in_valid) begin
      if (wst_q == SYNC) begin
        if (in_first) begin
          wr_en = 1'b1;
          waddr = '0;
          wk_d = LOG2N'(1);
          wst_d = FILL;
        end
      end else if (in_first && wk_q != '0) begin
        wr_en = 1'b1;
        waddr = '0;
        wk_d = LOG2N'(1);
        frame_err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        wk_d = wk_q + 1'b1;
        set_full = wk_q == '1;
        wsel_d = wsel_q ^ (wk_q == '1);
      end
    end
  end
  // Idle reads fire as soon as the bank is full, so X[0] lands two cycles after the last write.
  always_comb begin
    fire = rd_q == RD_RUN || full_q[rsel_q];
    rd_d = rd_q;
    rn_d = rn_q;
    rsel_d = rsel_q;
    clr_full = 1'b0;
    out_d = out_q;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    if (fire) begin
      out_d = rdata[rsel_q];
      out_valid_d = 1'b1;
      out_first_d = rn_q == '0;
      rn_d = rn_q + 1'b1;
      rd_d = RD_RUN;
      if (rn_q == '1) begin
        clr_full = 1'b1;
        rsel_d = ~rsel_q;
        rd_d = full_q[~rsel_q] ? RD_RUN : RD_IDLE;
      end
    end
    full_d = full_q;
    if (clr_full) full_d[rsel_q] = 1'b0;
    if (set_full) full_d[wsel_q] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wst_q <= SYNC;
      rd_q <= RD_IDLE;
      wk_q <= '0;
      rn_q <= '0;
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      full_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wst_q <= wst_d;
      rd_q <= rd_d;
      wk_q <= wk_d;
      rn_q <= rn_d;
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      full_q <= full_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      frame_err_q <= frame_err_d;
    end
  assign out = out_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign frame_err = frame_err_q;
endmodule
